alarm_sequencer: RTL
====================

Name: alarm_sequencer

Overview:
Controller that sequences the alarm-day decoder (alarm_struct / alarm_behav).
- Keeps wall-clock time: minute, hour and day-of-week.
- Drives day[2:0] into the external decoder and receives its day-enable output back as day_en.
- Compares the current time against a programmable alarm time.
- Runs the ring/snooze/stop state machine that drives the buzzer.

Parameters:
- SNOOZE_MIN, 9: minutes spent in SNOOZE before re-ringing; range 1..63.
- RING_TIMEOUT_MIN, 30: minutes of unattended ringing before automatic stop; range 1..63.
- MAX_SNOOZE, 3: snoozes allowed per alarm event; range 0..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- min_tick  in  1  one-cycle pulse, once per minute.
- set_time  in  1  load set_day/set_hour/set_min into the time counters.
- set_day  in  3  day to load; value 7 loads as 0.
- set_hour  in  5  hour to load; values above 23 load as 0.
- set_min  in  6  minute to load; values above 59 load as 0.
- alarm_wr  in  1  write alarm_hour, alarm_min and alarm_arm.
- alarm_hour  in  5  alarm hour; values above 23 are stored but can never match.
- alarm_min  in  6  alarm minute; values above 59 are stored but can never match.
- alarm_arm  in  1  arm bit written with the alarm time.
- day_en  in  1  decoder output for the current day; combinational from the day output.
- stop  in  1  user stop pulse.
- snooze  in  1  user snooze pulse.
- day  out  3  current day, 0..6, registered.
- hour  out  5  current hour, 0..23, registered.
- minute  out  6  current minute, 0..59, registered.
- ring  out  1  buzzer enable.
- snoozing  out  1  high while in SNOOZE.
- snooze_left  out  3  snoozes remaining in the current event.

Behaviour:
Reset (rst_n low, asynchronous):
- day, hour and minute are 0.
- Stored alarm time is 00:00, disarmed.
- State is IDLE; ring=0, snoozing=0, snooze_left=MAX_SNOOZE.

Time counter:
- On min_tick, minute increments.
- minute 59 wraps to 0 and carries into hour.
- hour 23 wraps to 0 and carries into day.
- day 6 wraps to 0.
- set_time overrides min_tick when both occur in the same cycle.

Alarm registers:
- alarm_wr updates the stored alarm time and arm bit on the next edge.

Match detection:
- tick_q is min_tick registered one cycle.
- trigger = tick_q & armed & day_en & ({hour,minute} == stored alarm time).
- Counters updated by set_time never trigger.
- Latency: min_tick in cycle N updates the counters at the end of N. trigger is evaluated in N+1, and ring is high from N+2.

FSM states: IDLE, RINGING, SNOOZE.
- IDLE -> RINGING on trigger:
  - ring timer cleared;
  - snooze_left reloaded to MAX_SNOOZE.
- RINGING:
  - ring=1.
  - Each min_tick increments the ring timer.
  - stop -> IDLE.
  - snooze with snooze_left>0 -> SNOOZE; snooze_left decrements and the snooze countdown loads SNOOZE_MIN.
  - snooze with snooze_left==0 is ignored.
  - Ring timer reaching RING_TIMEOUT_MIN -> IDLE.
- SNOOZE:
  - ring=0, snoozing=1.
  - Each min_tick decrements the countdown.
  - Countdown reaching 0 -> RINGING, with the ring timer cleared.
  - stop -> IDLE.
  - snooze is ignored.
- Priority within a cycle: alarm_wr with alarm_arm=0 (disarm) > stop > timeout/countdown expiry > snooze.
  - Disarm forces IDLE from any state.
  - A trigger arriving while in RINGING or SNOOZE is ignored; no re-entry.
- Mid-operation reset returns all state to the reset values immediately and asynchronously.

Arithmetic:
- All counters are unsigned and saturate only at the wrap or limit values stated above.
- No combinational path from the inputs to ring.

Decomposition:
- Package alarm_pkg contains:
  - the FSM state enum (IDLE, RINGING, SNOOZE);
  - constants DAYS_PER_WEEK=7, HOURS=24, MINS=60;
  - width constants DAY_W=3, HOUR_W=5, MIN_W=6.
- Sub-module tod_counter holds the minute/hour/day counters, the set_time load and wrap logic, and produces tick_q.
- The FSM, the alarm registers and the compare logic stay in alarm_sequencer.

Test Plan:
1. Wrap: set_time 6/23:59, then one min_tick -> day=0, hour=0, minute=0, ring=0.
2. Trigger: alarm 07:00 armed, day_en=1, time 06:59, min_tick -> ring=1 exactly two cycles after the tick.
   Repeat with day_en=0 -> ring stays 0.
3. Snooze: from ringing, snooze -> ring=0, snoozing=1, snooze_left=2. After 9 min_ticks -> ring=1.
   Snooze 3 times, then a 4th snooze is ignored (ring stays 1, snooze_left=0).
4. Timeout: ringing with no input for 30 min_ticks -> IDLE, ring=0 on the 30th tick.
   The time is then 07:30, so no re-trigger occurs.
5. Priority: stop and snooze in the same cycle while RINGING -> IDLE, snoozing=0.
   set_time to 07:00 while armed -> no ring.
   set_time and min_tick in the same cycle -> loaded value wins.
6. Reset mid-SNOOZE: drop rst_n asynchronously -> ring=0, snoozing=0, alarm disarmed, time 0/00:00 with no clock edge required.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer and its time-of-day counter.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  localparam int DAYS_PER_WEEK = 7;
  localparam int HOURS         = 24;
  localparam int MINS          = 60;

  localparam int DAY_W  = 3;
  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;

endpackage

// File: rtl/tod_counter.sv
// Minute/hour/day-of-week counter with a sanitising load and a one-cycle delayed tick.
module tod_counter
  import alarm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              min_tick,
  input  logic              set_time,
  input  logic [DAY_W-1:0]  set_day,
  input  logic [HOUR_W-1:0] set_hour,
  input  logic [MIN_W-1:0]  set_min,
  output logic [DAY_W-1:0]  day,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  minute,
  output logic              tick_q
);

  localparam logic [DAY_W-1:0]  DAY_LAST  = DAY_W'(DAYS_PER_WEEK - 1);
  localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOURS - 1);
  localparam logic [MIN_W-1:0]  MIN_LAST  = MIN_W'(MINS - 1);

  logic [DAY_W-1:0]  load_day;
  logic [HOUR_W-1:0] load_hour;
  logic [MIN_W-1:0]  load_min;

  assign load_day  = (set_day  > DAY_LAST)  ? '0 : set_day;
  assign load_hour = (set_hour > HOUR_LAST) ? '0 : set_hour;
  assign load_min  = (set_min  > MIN_LAST)  ? '0 : set_min;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day    <= '0;
      hour   <= '0;
      minute <= '0;
      tick_q <= 1'b0;
    end else begin
      // A loaded time must never look like a fresh minute to the match logic.
      tick_q <= min_tick & ~set_time;
      if (set_time) begin
        day    <= load_day;
        hour   <= load_hour;
        minute <= load_min;
      end else if (min_tick) begin
        if (minute == MIN_LAST) begin
          minute <= '0;
          if (hour == HOUR_LAST) begin
            hour <= '0;
            day  <= (day == DAY_LAST) ? '0 : day + DAY_W'(1);
          end else begin
            hour <= hour + HOUR_W'(1);
          end
        end else begin
          minute <= minute + MIN_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm controller: keeps time, matches the programmed alarm and runs the ring/snooze/stop FSM.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN       = 9,
  parameter int RING_TIMEOUT_MIN = 30,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              min_tick,
  input  logic              set_time,
  input  logic [DAY_W-1:0]  set_day,
  input  logic [HOUR_W-1:0] set_hour,
  input  logic [MIN_W-1:0]  set_min,
  input  logic              alarm_wr,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic [MIN_W-1:0]  alarm_min,
  input  logic              alarm_arm,
  input  logic              day_en,
  input  logic              stop,
  input  logic              snooze,
  output logic [DAY_W-1:0]  day,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  minute,
  output logic              ring,
  output logic              snoozing,
  output logic [2:0]        snooze_left
);

  localparam logic [5:0] TIMEOUT_LAST = 6'(RING_TIMEOUT_MIN - 1);
  localparam logic [5:0] SNOOZE_LOAD  = 6'(SNOOZE_MIN);
  localparam logic [2:0] SNOOZE_MAX   = 3'(MAX_SNOOZE);

  logic              tick_q;
  logic [HOUR_W-1:0] alarm_hour_q;
  logic [MIN_W-1:0]  alarm_min_q;
  logic              armed;
  logic              trigger;
  logic              disarm;

  state_t     state, state_nxt;
  logic [5:0] ring_timer, ring_timer_nxt;
  logic [5:0] countdown, countdown_nxt;
  logic [2:0] snooze_left_nxt;

  tod_counter u_tod (
    .clk      (clk),
    .rst_n    (rst_n),
    .min_tick (min_tick),
    .set_time (set_time),
    .set_day  (set_day),
    .set_hour (set_hour),
    .set_min  (set_min),
    .day      (day),
    .hour     (hour),
    .minute   (minute),
    .tick_q   (tick_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_hour_q <= '0;
      alarm_min_q  <= '0;
      armed        <= 1'b0;
    end else if (alarm_wr) begin
      alarm_hour_q <= alarm_hour;
      alarm_min_q  <= alarm_min;
      armed        <= alarm_arm;
    end
  end

  // Counters never exceed 23:59, so an out-of-range stored alarm simply never compares equal.
  assign trigger = tick_q & armed & day_en & (hour == alarm_hour_q) & (minute == alarm_min_q);
  assign disarm  = alarm_wr & ~alarm_arm;

  always_comb begin
    state_nxt       = state;
    ring_timer_nxt  = ring_timer;
    countdown_nxt   = countdown;
    snooze_left_nxt = snooze_left;
    if (disarm || stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state_nxt       = RINGING;
            ring_timer_nxt  = '0;
            snooze_left_nxt = SNOOZE_MAX;
          end
        end
        RINGING: begin
          if (min_tick && ring_timer == TIMEOUT_LAST) begin
            state_nxt = IDLE;
          end else begin
            if (min_tick) ring_timer_nxt = ring_timer + 6'd1;
            if (snooze && snooze_left != 3'd0) begin
              state_nxt       = SNOOZE;
              snooze_left_nxt = snooze_left - 3'd1;
              countdown_nxt   = SNOOZE_LOAD;
            end
          end
        end
        SNOOZE: begin
          if (min_tick) begin
            if (countdown == 6'd1) begin
              state_nxt      = RINGING;
              ring_timer_nxt = '0;
            end else begin
              countdown_nxt = countdown - 6'd1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ring_timer  <= '0;
      countdown   <= '0;
      snooze_left <= SNOOZE_MAX;
    end else begin
      state       <= state_nxt;
      ring_timer  <= ring_timer_nxt;
      countdown   <= countdown_nxt;
      snooze_left <= snooze_left_nxt;
    end
  end

  assign ring     = (state == RINGING);
  assign snoozing = (state == SNOOZE);

endmodule
